// File: rtl/mbist_op_exec_if.sv
// Operation/SRAM/status bundle for mbist_op_exec: the master side is the sequencer, the SRAM
// read-data source and the status consumer; the slave side is the execution/compare block.
interface mbist_op_exec_if #(
    parameter int BIST_ADDR_WD    = 9,
    parameter int BIST_DATA_WD    = 32,
    parameter int BIST_ERR_CNT_WD = 8
);
    logic                       run;
    logic                       op_read;
    logic                       op_write;
    logic                       op_invert;
    logic [BIST_ADDR_WD-1:0]    op_addr;
    logic [BIST_DATA_WD-1:0]    pat_data;
    logic                       clear;
    logic                       mem_cs;
    logic                       mem_we;
    logic [BIST_ADDR_WD-1:0]    mem_addr;
    logic [BIST_DATA_WD-1:0]    mem_wdata;
    logic [BIST_DATA_WD-1:0]    mem_rdata;
    logic                       cmp_busy;
    logic                       err_pulse;
    logic                       fail;
    logic [BIST_ERR_CNT_WD-1:0] err_cnt;
    logic [BIST_ADDR_WD-1:0]    err_addr;
    logic [BIST_DATA_WD-1:0]    err_syndrome;

    modport master (
        output run, op_read, op_write, op_invert, op_addr, pat_data, clear, mem_rdata,
        input  mem_cs, mem_we, mem_addr, mem_wdata, cmp_busy, err_pulse, fail, err_cnt,
               err_addr, err_syndrome
    );

    modport slave (
        input  run, op_read, op_write, op_invert, op_addr, pat_data, clear, mem_rdata,
        output mem_cs, mem_we, mem_addr, mem_wdata, cmp_busy, err_pulse, fail, err_cnt,
               err_addr, err_syndrome
    );
endinterface

// File: rtl/mbist_op_exec.sv
// MBIST execution/compare stage: drives one SRAM port and checks read data against the background.
// Optional first-failure log is built when MBIST_ERR_LOG_EN is defined.
module mbist_op_exec #(
    parameter int BIST_ADDR_WD    = 9,
    parameter int BIST_DATA_WD    = 32,
    parameter int BIST_RD_LAT     = 1,
    parameter int BIST_ERR_CNT_WD = 8
) (
    input logic            clk,
    input logic            rst_n,
    mbist_op_exec_if.slave bus
);
    localparam int AW  = BIST_ADDR_WD;
    localparam int DW  = BIST_DATA_WD;
    localparam int LAT = BIST_RD_LAT;
    localparam int CW  = BIST_ERR_CNT_WD;
    localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

    logic           iss_any_s;
    logic           iss_wr_s;
    logic           iss_rd_s;
    logic [DW-1:0]  exp_s;
    logic [DW-1:0]  syn_s;
    logic           miscmp_s;
    logic [CW-1:0]  cnt_base_s;

    logic           mem_cs_q;
    logic           mem_we_q;
    logic [AW-1:0]  mem_addr_q;
    logic [DW-1:0]  mem_wdata_q;
    logic [DW-1:0]  iss_exp_q;
    logic [LAT-1:0] pvld_q, pvld_d;
    logic [DW-1:0]  pexp_q [LAT];
    logic           cmp_busy_q, cmp_busy_d;
    logic           err_pulse_q;
    logic           fail_q, fail_d;
    logic [CW-1:0]  err_cnt_q, err_cnt_d;

    // Issue decode; a simultaneous read+write is treated as a write only.
    always_comb begin
        iss_any_s = bus.run & (bus.op_read | bus.op_write);
        iss_wr_s  = bus.run & bus.op_write;
        iss_rd_s  = bus.run & bus.op_read & ~bus.op_write;
        exp_s     = bus.op_invert ? ~bus.pat_data : bus.pat_data;
    end

    // Registered SRAM port; address holds when no operation is issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_cs_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            iss_exp_q   <= '0;
        end else begin
            mem_cs_q    <= iss_any_s;
            mem_we_q    <= iss_wr_s;
            mem_wdata_q <= iss_wr_s ? exp_s : '0;
            if (iss_any_s) begin
                mem_addr_q <= bus.op_addr;
            end
            if (iss_rd_s) begin
                iss_exp_q <= exp_s;
            end
        end
    end

    // Next-state of the read-tracking valid chain and the busy flag derived from it.
    always_comb begin
        pvld_d    = '0;
        pvld_d[0] = mem_cs_q & ~mem_we_q;
        for (int i = 1; i < LAT; i++) begin
            pvld_d[i] = pvld_q[i-1];
        end
        cmp_busy_d = iss_rd_s | (|pvld_d);
    end

    // Expected-data pipeline aligned with the SRAM read latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pvld_q     <= '0;
            cmp_busy_q <= 1'b0;
            for (int i = 0; i < LAT; i++) begin
                pexp_q[i] <= '0;
            end
        end else begin
            pvld_q     <= pvld_d;
            cmp_busy_q <= cmp_busy_d;
            pexp_q[0]  <= iss_exp_q;
            for (int i = 1; i < LAT; i++) begin
                pexp_q[i] <= pexp_q[i-1];
            end
        end
    end

    // Compare at the pipeline tap; clear wipes status but a same-cycle miscompare still counts.
    always_comb begin
        syn_s      = bus.mem_rdata ^ pexp_q[LAT-1];
        miscmp_s   = pvld_q[LAT-1] & (|syn_s);
        cnt_base_s = bus.clear ? '0 : err_cnt_q;
        if (miscmp_s) begin
            fail_d    = 1'b1;
            err_cnt_d = (cnt_base_s == {CW{1'b1}}) ? cnt_base_s : cnt_base_s + CNT_ONE;
        end else begin
            fail_d    = fail_q & ~bus.clear;
            err_cnt_d = cnt_base_s;
        end
    end

    // Status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_pulse_q <= 1'b0;
            fail_q      <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            err_pulse_q <= miscmp_s;
            fail_q      <= fail_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

`ifdef MBIST_ERR_LOG_EN
    logic [AW-1:0] paddr_q [LAT];
    logic          log_vld_q;
    logic [AW-1:0] err_addr_q;
    logic [DW-1:0] err_syn_q;

    // Address pipeline (log build only) and first-failure capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LAT; i++) begin
                paddr_q[i] <= '0;
            end
            log_vld_q  <= 1'b0;
            err_addr_q <= '0;
            err_syn_q  <= '0;
        end else begin
            paddr_q[0] <= mem_addr_q;
            for (int i = 1; i < LAT; i++) begin
                paddr_q[i] <= paddr_q[i-1];
            end
            if (miscmp_s && (bus.clear || !log_vld_q)) begin
                log_vld_q  <= 1'b1;
                err_addr_q <= paddr_q[LAT-1];
                err_syn_q  <= syn_s;
            end else if (bus.clear) begin
                log_vld_q  <= 1'b0;
                err_addr_q <= '0;
                err_syn_q  <= '0;
            end
        end
    end

    assign bus.err_addr     = err_addr_q;
    assign bus.err_syndrome = err_syn_q;
`else
    assign bus.err_addr     = '0;
    assign bus.err_syndrome = '0;
`endif

    assign bus.mem_cs    = mem_cs_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.cmp_busy  = cmp_busy_q;
    assign bus.err_pulse = err_pulse_q;
    assign bus.fail      = fail_q;
    assign bus.err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_mbist_op_exec.sv
// Self-checking bench for mbist_op_exec: directed scenarios plus a random phase, checked every
// cycle against a cycle-indexed reference of expected pulses, busy windows and status.
module tb_mbist_op_exec;
    localparam int AW  = 9;
    localparam int DW  = 32;
    localparam int LAT = 3;
    localparam int CW  = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    mbist_op_exec_if #(.BIST_ADDR_WD(AW), .BIST_DATA_WD(DW), .BIST_ERR_CNT_WD(CW)) bif ();

    mbist_op_exec #(
        .BIST_ADDR_WD(AW), .BIST_DATA_WD(DW), .BIST_RD_LAT(LAT), .BIST_ERR_CNT_WD(CW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif.slave)
    );

    // SRAM model with LAT-cycle read latency and a per-address stuck-bit fault mask.
    logic [DW-1:0] sram  [512] = '{default: 32'h0};
    logic [DW-1:0] fault [512] = '{default: 32'h0};
    logic [DW-1:0] rdq   [LAT] = '{default: 32'h0};
    always @(posedge clk) begin
        if (bif.mem_cs && bif.mem_we) sram[bif.mem_addr] <= bif.mem_wdata;
        rdq[0] <= (bif.mem_cs && !bif.mem_we) ? (sram[bif.mem_addr] ^ fault[bif.mem_addr]) : 32'h0;
        for (int i = 1; i < LAT; i++) rdq[i] <= rdq[i-1];
    end
    assign bif.mem_rdata = rdq[LAT-1];

    // Reference model state
    int            cyc = 0;
    int            n_asrt = 0;
    int            n_fail = 0;
    logic [DW-1:0] shadow [512];
    bit            pulse_at [int];
    bit            busy_at  [int];
    bit            clr_at   [int];
    logic [AW-1:0] paddr_at [int];
    logic [DW-1:0] psyn_at  [int];
    logic          m_cs, m_we, m_fail, m_logged;
    logic [AW-1:0] m_addr, m_eaddr;
    logic [DW-1:0] m_wdata, m_esyn;
    logic [CW-1:0] m_cnt;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
        n_asrt++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, expv);
        end
    endtask

    task automatic check_all(input string ph);
        chk({ph, ":mem_cs"},    32'(bif.mem_cs),    32'(m_cs));
        chk({ph, ":mem_we"},    32'(bif.mem_we),    32'(m_we));
        chk({ph, ":mem_addr"},  32'(bif.mem_addr),  32'(m_addr));
        chk({ph, ":mem_wdata"}, bif.mem_wdata,      m_wdata);
        chk({ph, ":cmp_busy"},  32'(bif.cmp_busy),  32'(busy_at.exists(cyc)));
        chk({ph, ":err_pulse"}, 32'(bif.err_pulse), 32'(pulse_at.exists(cyc)));
        chk({ph, ":fail"},      32'(bif.fail),      32'(m_fail));
        chk({ph, ":err_cnt"},   32'(bif.err_cnt),   32'(m_cnt));
`ifdef MBIST_ERR_LOG_EN
        chk({ph, ":err_addr"},  32'(bif.err_addr),  32'(m_eaddr));
        chk({ph, ":err_syn"},   bif.err_syndrome,   m_esyn);
`else
        chk({ph, ":err_addr"},  32'(bif.err_addr),  32'h0);
        chk({ph, ":err_syn"},   bif.err_syndrome,   32'h0);
`endif
    endtask

    task automatic model_clear_all();
        m_cs = 1'b0; m_we = 1'b0; m_addr = '0; m_wdata = '0;
        m_fail = 1'b0; m_cnt = '0; m_logged = 1'b0; m_eaddr = '0; m_esyn = '0;
        pulse_at.delete(); busy_at.delete(); clr_at.delete();
        paddr_at.delete(); psyn_at.delete();
    endtask

    task automatic step(input string ph, input bit r, input bit rd, input bit wr, input bit inv,
                        input logic [AW-1:0] a, input logic [DW-1:0] p, input bit clr);
        logic [DW-1:0] e, rv;
        bif.run = r; bif.op_read = rd; bif.op_write = wr; bif.op_invert = inv;
        bif.op_addr = a; bif.pat_data = p; bif.clear = clr;
        e = inv ? ~p : p;
        if (r && wr) begin
            shadow[a] = e;
        end else if (r && rd) begin
            rv = shadow[a] ^ fault[a];
            for (int k = 1; k <= LAT + 1; k++) busy_at[cyc + k] = 1'b1;
            if (rv !== e) begin
                pulse_at[cyc + LAT + 2] = 1'b1;
                paddr_at[cyc + LAT + 2] = a;
                psyn_at[cyc + LAT + 2]  = rv ^ e;
            end
        end
        if (clr) clr_at[cyc] = 1'b1;
        @(posedge clk); #1; cyc++;
        m_cs    = r && (rd || wr);
        m_we    = r && wr;
        m_wdata = (r && wr) ? e : 32'h0;
        if (m_cs) m_addr = a;
        if (clr_at.exists(cyc - 1)) begin
            m_fail = 1'b0; m_cnt = '0; m_logged = 1'b0; m_eaddr = '0; m_esyn = '0;
        end
        if (pulse_at.exists(cyc)) begin
            m_fail = 1'b1;
            if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
            if (!m_logged) begin
                m_logged = 1'b1; m_eaddr = paddr_at[cyc]; m_esyn = psyn_at[cyc];
            end
        end
        check_all(ph);
    endtask

    task automatic idle(input string ph, input int n);
        for (int i = 0; i < n; i++) step(ph, 1'b0, 1'b0, 1'b0, 1'b0, 9'h000, 32'h0, 1'b0);
    endtask
    task automatic wr_op(input string ph, input logic [AW-1:0] a, input logic [DW-1:0] p, input bit inv);
        step(ph, 1'b1, 1'b0, 1'b1, inv, a, p, 1'b0);
    endtask
    task automatic rd_op(input string ph, input logic [AW-1:0] a, input logic [DW-1:0] p, input bit inv);
        step(ph, 1'b1, 1'b1, 1'b0, inv, a, p, 1'b0);
    endtask
    task automatic clr_op(input string ph);
        step(ph, 1'b0, 1'b0, 1'b0, 1'b0, 9'h000, 32'h0, 1'b1);
    endtask

    task automatic do_reset(input string ph, input int hold);
        bif.run = 1'b0; bif.op_read = 1'b0; bif.op_write = 1'b0; bif.op_invert = 1'b0;
        bif.op_addr = '0; bif.pat_data = '0; bif.clear = 1'b0;
        rst_n = 1'b0;
        #1;
        model_clear_all();
        check_all({ph, "_imm"});
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1; cyc++;
            check_all({ph, "_hold"});
        end
        rst_n = 1'b1;
    endtask

    initial begin
        logic [DW-1:0] pa, pb;
        for (int i = 0; i < 512; i++) shadow[i] = 32'h0;
        #2;
        do_reset("reset", 2);

        // 1: write then read back with good memory
        wr_op("t1", 9'h010, 32'hA5A5A5A5, 1'b0);
        rd_op("t1", 9'h010, 32'hA5A5A5A5, 1'b0);
        idle("t1", LAT + 3);

        // 2: inverted background; good read, then a single-bit fault
        wr_op("t2", 9'h020, 32'h0000FFFF, 1'b1);
        rd_op("t2", 9'h020, 32'h0000FFFF, 1'b1);
        idle("t2", LAT + 3);
        fault[9'h020] = 32'h00000001;
        rd_op("t2", 9'h020, 32'h0000FFFF, 1'b1);
        idle("t2", LAT + 3);
        fault[9'h020] = 32'h0;

        // 3: back-to-back reads with one faulty word
        clr_op("t3");
        for (int i = 0; i < 4; i++) wr_op("t3", 9'(i), 32'h12345678 + 32'(i), 1'b0);
        fault[9'h002] = 32'h00000100;
        for (int i = 0; i < 4; i++) rd_op("t3", 9'(i), 32'h12345678 + 32'(i), 1'b0);
        idle("t3", LAT + 3);
        fault[9'h002] = 32'h0;

        // 4: counter saturation, then clear colliding with a miscompare
        clr_op("t4");
        fault[9'h100] = 32'h00000001;
        for (int i = 0; i < 300; i++) rd_op("t4", 9'h100, 32'h0, 1'b0);
        idle("t4", LAT + 3);
        chk("t4:sat", 32'(bif.err_cnt), 32'h000000FF);
        rd_op("t4", 9'h100, 32'h0, 1'b0);
        idle("t4", LAT);
        clr_op("t4clr");
        idle("t4", 2);
        chk("t4:cnt_after_clr", 32'(bif.err_cnt), 32'h1);
        chk("t4:fail_after_clr", 32'(bif.fail), 32'h1);
        fault[9'h100] = 32'h0;

        // 5: first-failure log
        clr_op("t5");
        wr_op("t5", 9'h030, 32'hCAFE0000, 1'b0);
        wr_op("t5", 9'h040, 32'hCAFE0000, 1'b0);
        fault[9'h030] = 32'h00000010;
        fault[9'h040] = 32'h00000004;
        rd_op("t5", 9'h030, 32'hCAFE0000, 1'b0);
        rd_op("t5", 9'h040, 32'hCAFE0000, 1'b0);
        idle("t5", LAT + 3);
`ifdef MBIST_ERR_LOG_EN
        chk("t5:log_addr", 32'(bif.err_addr), 32'h030);
        chk("t5:log_syn", bif.err_syndrome, 32'h00000010);
`endif
        clr_op("t5");
        wr_op("t5", 9'h050, 32'h0BADF00D, 1'b0);
        fault[9'h050] = 32'h00000008;
        rd_op("t5", 9'h050, 32'h0BADF00D, 1'b0);
        idle("t5", LAT + 3);
`ifdef MBIST_ERR_LOG_EN
        chk("t5:log_addr2", 32'(bif.err_addr), 32'h050);
        chk("t5:log_syn2", bif.err_syndrome, 32'h00000008);
`endif
        fault[9'h030] = 32'h0; fault[9'h040] = 32'h0; fault[9'h050] = 32'h0;

        // Random phase over a small address window with random faults and clears
        for (int i = 0; i < 16; i++)
            fault[i] = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'h0;
        pa = 32'($urandom);
        pb = 32'($urandom);
        clr_op("rnd");
        for (int i = 0; i < 400; i++) begin
            step("rnd", ($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
                 9'($urandom_range(0, 15)), ($urandom_range(0, 1) != 0) ? pa : pb,
                 ($urandom_range(0, 31) == 0));
        end
        idle("rnd", LAT + 3);
        for (int i = 0; i < 16; i++) fault[i] = 32'h0;

        // 6: reset with reads in flight
        clr_op("t6");
        fault[9'h060] = 32'h00000001;
        fault[9'h061] = 32'h00000002;
        rd_op("t6", 9'h060, 32'h0, 1'b0);
        rd_op("t6", 9'h061, 32'h0, 1'b0);
        do_reset("t6rst", 2);
        idle("t6", LAT + 4);
        chk("t6:fail_post", 32'(bif.fail), 32'h0);
        chk("t6:cnt_post", 32'(bif.err_cnt), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end
endmodule
